// File: rtl/vball_rom_loader.sv
// ioctl download router: index 0 bytes -> CPU/sound BRAM ports or packed 16-bit SDRAM writes, index 254 -> DIP regs.
// BRAM write and sd_req one cycle after strobe; ioctl_wait stalls hps_io until one cycle after sd_ack.
module vball_rom_loader #(
    parameter logic [31:0] CPU_SIZE = 32'h10000,
    parameter logic [31:0] SND_SIZE = 32'h08000,
    parameter logic [31:0] GFX_SIZE = 32'h80000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        cpu_we,
    output logic [15:0] cpu_addr,
    output logic [7:0]  cpu_data,
    output logic        snd_we,
    output logic [14:0] snd_addr,
    output logic [7:0]  snd_data,
    output logic        sd_req,
    input  logic        sd_ack,
    output logic [18:0] sd_addr,
    output logic [15:0] sd_data,
    output logic [7:0]  dsw0,
    output logic [7:0]  dsw1,
    output logic [7:0]  dsw2,
    output logic [7:0]  dsw3,
    output logic [7:0]  dsw4,
    output logic [7:0]  dsw5,
    output logic [7:0]  dsw6,
    output logic [7:0]  dsw7,
    output logic        done,
    output logic        overflow
);
    localparam logic [31:0] GFX_BASE = CPU_SIZE + SND_SIZE;
    localparam logic [31:0] GFX_END  = GFX_BASE + GFX_SIZE;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT_ACK, S_FLUSH, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        dl_q;
    logic        cpu_we_q, cpu_we_d, snd_we_q, snd_we_d;
    logic [15:0] cpu_addr_q, cpu_addr_d;
    logic [7:0]  cpu_data_q, cpu_data_d, snd_data_q, snd_data_d;
    logic [14:0] snd_addr_q, snd_addr_d;
    logic        sd_req_q, sd_req_d, wait_q, wait_d;
    logic [18:0] sd_addr_q, sd_addr_d, pend_addr_q, pend_addr_d;
    logic [15:0] sd_data_q, sd_data_d;
    logic        pend_q, pend_d;
    logic [7:0]  lo_q, lo_d;
    logic        done_q, done_d, ovf_q, ovf_d;
    logic [7:0]  dsw_q [8];

    logic [31:0] addr32;
    logic        in_cpu, in_snd, in_gfx, rom_wr;
    logic [14:0] snd_off;
    logic [18:0] gfx_off;

    assign addr32  = {7'b0, ioctl_addr};
    assign in_cpu  = addr32 < CPU_SIZE;
    assign in_snd  = !in_cpu && (addr32 < GFX_BASE);
    assign in_gfx  = (addr32 >= GFX_BASE) && (addr32 < GFX_END);
    assign snd_off = 15'(ioctl_addr - 25'(CPU_SIZE));
    assign gfx_off = 19'(ioctl_addr - 25'(GFX_BASE));
    assign rom_wr  = ioctl_wr && (ioctl_index == 8'd0);

    always_comb begin
        state_d     = state_q;
        cpu_we_d    = 1'b0;
        cpu_addr_d  = cpu_addr_q;
        cpu_data_d  = cpu_data_q;
        snd_we_d    = 1'b0;
        snd_addr_d  = snd_addr_q;
        snd_data_d  = snd_data_q;
        sd_req_d    = sd_req_q;
        wait_d      = wait_q;
        sd_addr_d   = sd_addr_q;
        sd_data_d   = sd_data_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        lo_d        = lo_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (ioctl_download && !dl_q && (ioctl_index == 8'd0)) begin
                    state_d = S_LOAD;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            S_LOAD: begin
                if (!ioctl_download) begin
                    state_d = pend_q ? S_FLUSH : S_DONE;
                end else if (rom_wr) begin
                    if (in_cpu) begin
                        cpu_we_d   = 1'b1;
                        cpu_addr_d = ioctl_addr[15:0];
                        cpu_data_d = ioctl_dout;
                    end else if (in_snd) begin
                        snd_we_d   = 1'b1;
                        snd_addr_d = snd_off;
                        snd_data_d = ioctl_dout;
                    end else if (in_gfx) begin
                        if (!gfx_off[0]) begin
                            lo_d        = ioctl_dout;
                            pend_d      = 1'b1;
                            pend_addr_d = gfx_off;
                        end else begin
                            // An odd byte with no preceding even byte pads the low half with zero.
                            sd_data_d = {ioctl_dout, pend_q ? lo_q : 8'h00};
                            sd_addr_d = {gfx_off[18:1], 1'b0};
                            sd_req_d  = 1'b1;
                            wait_d    = 1'b1;
                            pend_d    = 1'b0;
                            state_d   = S_WAIT_ACK;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (sd_ack) begin
                    sd_req_d = 1'b0;
                    wait_d   = 1'b0;
                    if (ioctl_download) state_d = S_LOAD;
                    else                state_d = pend_q ? S_FLUSH : S_DONE;
                end
            end
            S_FLUSH: begin
                if (!sd_req_q) begin
                    sd_req_d  = 1'b1;
                    sd_addr_d = pend_addr_q;
                    sd_data_d = {8'h00, lo_q};
                end else if (sd_ack) begin
                    sd_req_d = 1'b0;
                    pend_d   = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            dl_q        <= 1'b0;
            cpu_we_q    <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_data_q  <= '0;
            snd_we_q    <= 1'b0;
            snd_addr_q  <= '0;
            snd_data_q  <= '0;
            sd_req_q    <= 1'b0;
            wait_q      <= 1'b0;
            sd_addr_q   <= '0;
            sd_data_q   <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            for (int i = 0; i < 8; i++) dsw_q[i] <= 8'hFF;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            cpu_we_q    <= cpu_we_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_data_q  <= cpu_data_d;
            snd_we_q    <= snd_we_d;
            snd_addr_q  <= snd_addr_d;
            snd_data_q  <= snd_data_d;
            sd_req_q    <= sd_req_d;
            wait_q      <= wait_d;
            sd_addr_q   <= sd_addr_d;
            sd_data_q   <= sd_data_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            lo_q        <= lo_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            // DIP bytes are captured in any state and never stall hps_io.
            if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0))
                dsw_q[ioctl_addr[2:0]] <= ioctl_dout;
        end
    end

    assign ioctl_wait = wait_q;
    assign cpu_we     = cpu_we_q;
    assign cpu_addr   = cpu_addr_q;
    assign cpu_data   = cpu_data_q;
    assign snd_we     = snd_we_q;
    assign snd_addr   = snd_addr_q;
    assign snd_data   = snd_data_q;
    assign sd_req     = sd_req_q;
    assign sd_addr    = sd_addr_q;
    assign sd_data    = sd_data_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign dsw0 = dsw_q[0];
    assign dsw1 = dsw_q[1];
    assign dsw2 = dsw_q[2];
    assign dsw3 = dsw_q[3];
    assign dsw4 = dsw_q[4];
    assign dsw5 = dsw_q[5];
    assign dsw6 = dsw_q[6];
    assign dsw7 = dsw_q[7];
endmodule

// File: tb/tb_vball_rom_loader.sv
// Directed bench for vball_rom_loader: CPU/sound/gfx routing, flush, DIP capture, overflow, async reset.
module tb_vball_rom_loader;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        cpu_we, snd_we, sd_req, sd_ack, done, overflow;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data, snd_data;
    logic [14:0] snd_addr;
    logic [18:0] sd_addr;
    logic [15:0] sd_data;
    logic [7:0]  dsw [8];

    int checks = 0;
    int errors = 0;
    int wait_cnt;

    always #5 clk_sys = ~clk_sys;

    vball_rom_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .snd_we(snd_we), .snd_addr(snd_addr), .snd_data(snd_data),
        .sd_req(sd_req), .sd_ack(sd_ack), .sd_addr(sd_addr), .sd_data(sd_data),
        .dsw0(dsw[0]), .dsw1(dsw[1]), .dsw2(dsw[2]), .dsw3(dsw[3]),
        .dsw4(dsw[4]), .dsw5(dsw[5]), .dsw6(dsw[6]), .dsw7(dsw[7]),
        .done(done), .overflow(overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; sd_ack = 1'b0;
        tick(); tick();
        check("rst_cpu_we", {31'd0, cpu_we}, 0);
        check("rst_sd_req", {31'd0, sd_req}, 0);
        check("rst_wait", {31'd0, ioctl_wait}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_dsw0", {24'd0, dsw[0]}, 32'hFF);
        check("rst_dsw7", {24'd0, dsw[7]}, 32'hFF);
        reset_n = 1'b1;
        tick();

        // CPU region: four bytes
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            wr_byte(8'd0, 25'(i), 8'(i + 1));
            check("cpu_we", {31'd0, cpu_we}, 1);
            check("cpu_addr", {16'd0, cpu_addr}, i);
            check("cpu_data", {24'd0, cpu_data}, i + 1);
            check("cpu_no_sdreq", {31'd0, sd_req}, 0);
            tick();
            check("cpu_we_low", {31'd0, cpu_we}, 0);
        end
        ioctl_download = 1'b0;
        tick(); tick(); tick();
        check("cpu_done", {31'd0, done}, 1);

        // gfx word with a 5-cycle ack, then an odd-length tail flushed
        ioctl_download = 1'b1;
        tick(); tick();
        check("gfx_done_cleared", {31'd0, done}, 0);
        wr_byte(8'd0, 25'h18000, 8'hAA);
        check("gfx_even_no_req", {31'd0, sd_req}, 0);
        check("gfx_even_no_cpu", {31'd0, cpu_we}, 0);
        wr_byte(8'd0, 25'h18001, 8'hBB);
        check("gfx_req", {31'd0, sd_req}, 1);
        check("gfx_sd_addr", {13'd0, sd_addr}, 0);
        check("gfx_sd_data", {16'd0, sd_data}, 32'hBBAA);
        wait_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (ioctl_wait) wait_cnt++;
            tick();
        end
        if (ioctl_wait) wait_cnt++;
        check("gfx_req_held", {31'd0, sd_req}, 1);
        check("gfx_data_stable", {16'd0, sd_data}, 32'hBBAA);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        check("gfx_wait_cycles", wait_cnt, 5);
        check("gfx_req_drop", {31'd0, sd_req}, 0);
        check("gfx_wait_drop", {31'd0, ioctl_wait}, 0);
        wr_byte(8'd0, 25'h18002, 8'hCC);
        check("tail_no_req", {31'd0, sd_req}, 0);
        ioctl_download = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (sd_req) break;
            tick();
        end
        check("flush_req", {31'd0, sd_req}, 1);
        check("flush_addr", {13'd0, sd_addr}, 2);
        check("flush_data", {16'd0, sd_data}, 32'h00CC);
        check("flush_no_done_yet", {31'd0, done}, 0);
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        check("flush_req_drop", {31'd0, sd_req}, 0);
        tick(); tick();
        check("flush_done", {31'd0, done}, 1);

        // DIP switches; address 8 must be ignored
        wait_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            wr_byte(8'd254, 25'(i), 8'(8'h10 + i));
            if (ioctl_wait) wait_cnt++;
        end
        wr_byte(8'd254, 25'd8, 8'h55);
        tick();
        for (int i = 0; i < 8; i++) check("dsw", {24'd0, dsw[i]}, 32'h10 + i);
        check("dsw_no_wait", wait_cnt, 0);

        // overflow, then sound region, then a fresh download clears overflow
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick(); tick();
        check("ovf_start", {31'd0, overflow}, 0);
        wr_byte(8'd0, 25'h98000, 8'h5A);
        check("ovf_set", {31'd0, overflow}, 1);
        check("ovf_no_cpu", {31'd0, cpu_we}, 0);
        check("ovf_no_snd", {31'd0, snd_we}, 0);
        check("ovf_no_sd", {31'd0, sd_req}, 0);
        wr_byte(8'd0, 25'h10005, 8'h77);
        check("snd_we", {31'd0, snd_we}, 1);
        check("snd_addr", {17'd0, snd_addr}, 5);
        check("snd_data", {24'd0, snd_data}, 32'h77);
        check("snd_no_cpu", {31'd0, cpu_we}, 0);
        ioctl_download = 1'b0;
        tick(); tick(); tick();
        check("ovf_sticky", {31'd0, overflow}, 1);
        ioctl_download = 1'b1;
        tick(); tick();
        check("ovf_cleared", {31'd0, overflow}, 0);

        // reset while waiting for ack
        wr_byte(8'd0, 25'h18010, 8'h11);
        wr_byte(8'd0, 25'h18011, 8'h22);
        check("rw_req", {31'd0, sd_req}, 1);
        check("rw_data", {16'd0, sd_data}, 32'h2211);
        tick();
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check("rw_req_async", {31'd0, sd_req}, 0);
        check("rw_wait_async", {31'd0, ioctl_wait}, 0);
        tick();
        reset_n = 1'b1;
        tick(); tick();
        sd_ack = 1'b1;
        tick();
        sd_ack = 1'b0;
        tick();
        check("rw_req_after", {31'd0, sd_req}, 0);
        check("rw_dsw0", {24'd0, dsw[0]}, 32'hFF);
        check("rw_dsw3", {24'd0, dsw[3]}, 32'hFF);
        check("rw_done", {31'd0, done}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
